// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and the write-port priority helper for
// the multi-port register file. The optional pending-write scoreboard is
// enabled by defining REGFILE_MP_SCOREBOARD_EN.
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  // Upper bound on write ports; match vectors are padded to this width.
  localparam int MAX_WR   = 4;
  localparam int WR_IDX_W = 2;

  // Register 0 reads as zero and never stores anything.
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] idx;
  } wr_sel_t;

  // Highest-index set bit of a write-port match vector. Used both when
  // resolving simultaneous writes and when selecting the bypass source,
  // so both paths agree on the winning port.
  function automatic wr_sel_t last_match(input logic [MAX_WR-1:0] match);
    wr_sel_t r;
    r = '0;
    for (int k = 0; k < MAX_WR; k++) begin
      if (match[k]) begin
        r.hit = 1'b1;
        r.idx = WR_IDX_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: pending-write busy vector. Only instantiated when
// REGFILE_MP_SCOREBOARD_EN is defined. A set of an address wins over a
// retiring write to that same address in the same cycle.
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Which enabled write ports target address a (padded to MAX_WR bits).
  function automatic logic [MAX_WR-1:0] match_vec(
    input logic [NUM_WR-1:0]        wen,
    input logic [NUM_WR*ADDR_W-1:0] waddr,
    input logic [ADDR_W-1:0]        a
  );
    logic [MAX_WR-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      m[k] = wen[k] && (waddr[k*ADDR_W +: ADDR_W] == a);
    end
    return m;
  endfunction

  // Next busy state: set beats clear, register 0 never busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_set_en && (sb_set_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (|match_vec(wr_en, wr_addr, ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy vector register with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-port busy view, hidden while the producer is retiring this cycle.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_busy
      logic [ADDR_W-1:0] ra;
      assign ra = rd_addr[gi*ADDR_W +: ADDR_W];
      assign rd_busy[gi] = busy_q[ra] & ~(|match_vec(wr_en, wr_addr, ra));
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first bypass, hardwired
// zero register, write-conflict flag and an optional pending-write
// scoreboard (define REGFILE_MP_SCOREBOARD_EN to include it).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_conflict_q;
  logic              wr_conflict_d;

  // Which enabled write ports target address a (padded to MAX_WR bits).
  function automatic logic [MAX_WR-1:0] match_vec(
    input logic [NUM_WR-1:0]        wen,
    input logic [NUM_WR*ADDR_W-1:0] waddr,
    input logic [ADDR_W-1:0]        a
  );
    logic [MAX_WR-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      m[k] = wen[k] && (waddr[k*ADDR_W +: ADDR_W] == a);
    end
    return m;
  endfunction

  // Next array contents: highest-index matching port wins, r0 stays zero.
  always_comb begin
    wr_sel_t sel;
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      sel = last_match(match_vec(wr_en, wr_addr, ADDR_W'(i)));
      if (sel.hit) begin
        mem_d[i] = wr_data[int'(sel.idx)*DATA_W +: DATA_W];
      end
    end
    mem_d[REG_ZERO] = '0;
  end

  // Conflict when any two enabled ports share a nonzero address.
  always_comb begin
    wr_conflict_d = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (wr_en[a] && wr_en[b] &&
            (wr_addr[a*ADDR_W +: ADDR_W] == wr_addr[b*ADDR_W +: ADDR_W]) &&
            (wr_addr[a*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  // Array and conflict flag registers; reset overrides any write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  // Combinational read ports with write-first bypass.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      wr_sel_t           rsel;
      assign ra   = rd_addr[gi*ADDR_W +: ADDR_W];
      assign rsel = last_match(match_vec(wr_en, wr_addr, ra));

      // Zero register, then bypass, then stored value.
      always_comb begin
        if (ra == ADDR_W'(REG_ZERO)) begin
          rd_data[gi*DATA_W +: DATA_W] = '0;
        end else if (rsel.hit) begin
          rd_data[gi*DATA_W +: DATA_W] = wr_data[int'(rsel.idx)*DATA_W +: DATA_W];
        end else begin
          rd_data[gi*DATA_W +: DATA_W] = mem_q[ra];
        end
      end
    end
  endgenerate

`ifdef REGFILE_MP_SCOREBOARD_EN
  regfile_mp_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy)
  );
`else
  // Without the scoreboard nothing is ever pending.
  assign rd_busy = '0;
  logic unused_sb;
  assign unused_sb = &{1'b0, sb_set_en, sb_set_addr};
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized + directed bench with a behavioural model and a
// queue-based scoreboard; expectations are pushed by the driver and popped
// by a monitor on the falling clock edge.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
`ifdef REGFILE_MP_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             sb_set_en;
  logic [AW-1:0]    sb_set_addr;
  logic [NR-1:0]    rd_busy;
  logic             wr_conflict;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .rd_busy     (rd_busy),
    .wr_conflict (wr_conflict)
  );

  // Reference model state: register values, pending flags, conflict flag.
  logic [DW-1:0] m_mem  [32];
  logic          m_busy [32];
  logic          m_conf;

  typedef struct {
    int            id;
    logic [2*DW-1:0] rd;
    logic [1:0]    busy;
    logic          conf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   txn_id = 0;

  // Value a read of address ra must return given this cycle's writes.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra,
      input logic [1:0] we, input logic [AW-1:0] wa0, wa1,
      input logic [DW-1:0] wd0, wd1);
    if (ra == 0) return '0;
    if (we[1] && wa1 == ra) return wd1;
    if (we[0] && wa0 == ra) return wd0;
    return m_mem[ra];
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] ra,
      input logic [1:0] we, input logic [AW-1:0] wa0, wa1);
    if (!SB_EN) return 1'b0;
    if ((we[0] && wa0 == ra) || (we[1] && wa1 == ra)) return 1'b0;
    return m_busy[ra];
  endfunction

  // One clock cycle of stimulus: drive, predict, push, advance the model.
  task automatic step(input logic rst, input logic [1:0] we,
                      input logic [AW-1:0] wa0, wa1,
                      input logic [DW-1:0] wd0, wd1,
                      input logic sbe, input logic [AW-1:0] sba,
                      input logic [AW-1:0] ra0, ra1);
    exp_t e;
    @(posedge clock);
    #1;
    reset       = rst;
    wr_en       = we;
    wr_addr     = {wa1, wa0};
    wr_data     = {wd1, wd0};
    sb_set_en   = sbe;
    sb_set_addr = sba;
    rd_addr     = {ra1, ra0};

    e.id   = txn_id;
    e.rd   = {model_read(ra1, we, wa0, wa1, wd0, wd1),
              model_read(ra0, we, wa0, wa1, wd0, wd1)};
    e.busy = {model_busy(ra1, we, wa0, wa1), model_busy(ra0, we, wa0, wa1)};
    e.conf = m_conf;
    exp_q.push_back(e);
    txn_id++;

    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_conf = 1'b0;
    end else begin
      m_conf = (we == 2'b11) && (wa0 == wa1) && (wa0 != 0);
      if (we[0] && wa0 != 0) m_mem[wa0] = wd0;
      if (we[1] && wa1 != 0) m_mem[wa1] = wd1;
      if (we[0]) m_busy[wa0] = 1'b0;
      if (we[1]) m_busy[wa1] = 1'b0;
      if (sbe)   m_busy[sba] = 1'b1;
      m_busy[0] = 1'b0;
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      $display("txn %0d rd_data=%h rd_busy=%b wr_conflict=%b",
               mon_e.id, rd_data, rd_busy, wr_conflict);
      checks++;
      if (rd_data === mon_e.rd) passes++;
      else $display("FAIL rd_data txn %0d: got %h expected %h", mon_e.id, rd_data, mon_e.rd);
      checks++;
      if (rd_busy === mon_e.busy) passes++;
      else $display("FAIL rd_busy txn %0d: got %b expected %b", mon_e.id, rd_busy, mon_e.busy);
      checks++;
      if (wr_conflict === mon_e.conf) passes++;
      else $display("FAIL wr_conflict txn %0d: got %b expected %b", mon_e.id, wr_conflict, mon_e.conf);
    end
  end

  initial begin
    int w;
    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; sb_set_en = 1'b0; sb_set_addr = '0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0; m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;

    // Reset, then sweep every address.
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a += 2) step(0, 2'b00, 0, 0, 0, 0, 0, 0, AW'(a), AW'(a + 1));

    // Bypass and retention.
    step(0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);

    // Same-address conflict: port 1 wins, flag for one cycle.
    step(0, 2'b11, 7, 7, 32'h11, 32'h22, 0, 0, 7, 5);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 5);

    // Zero register ignores writes and never flags a conflict.
    step(0, 2'b01, 0, 0, 32'h55, 0, 0, 0, 0, 7);
    step(0, 2'b11, 0, 0, 32'h55, 32'h66, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Scoreboard set, clear, and set-beats-clear.
    step(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
    step(0, 2'b01, 3, 0, 32'h33, 0, 0, 0, 3, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0);
    step(0, 2'b01, 3, 0, 32'h34, 0, 1, 3, 3, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);

    // Reset dominating a write and a pending set.
    step(0, 2'b01, 9, 0, 32'hAA, 0, 1, 9, 9, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
    step(1, 2'b01, 9, 0, 32'hBB, 0, 1, 9, 9, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 3);

    // Random traffic concentrated on a few registers to force collisions.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0),
           2'($urandom_range(0, 3)),
           AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11)),
           $urandom, $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 11)),
           AW'($urandom_range(0, 11)), AW'($urandom_range(0, 31)));
    end
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    w = 0;
    while (exp_q.size() > 0 && w < 20) begin
      @(posedge clock);
      w++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: configurable width, depth, number of read ports and number of write ports. Provides write-first bypass, a hardwired-zero register 0, write-port conflict detection, and an optional pending-write scoreboard. It sits in the decode/writeback stage of the core. It serves superscalar issue, where several operands are read and several results are retired per cycle.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..8)
- NUM_WR, 2, number of write ports (1..4)

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W]
- wr_data  in  NUM_WR*DATA_W  write data, port k at [k*DATA_W +: DATA_W]
- rd_addr  in  NUM_RD*ADDR_W  read addresses, packed as above
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- sb_set_en  in  1  mark sb_set_addr as pending (instruction issued)
- sb_set_addr  in  ADDR_W  destination being marked pending
- rd_busy  out  NUM_RD  read port j's register has a pending write
- wr_conflict  out  1  registered flag: two or more enabled write ports targeted the same nonzero address last cycle

## Operation
- Storage: DEPTH x DATA_W array plus a DEPTH-bit busy vector.
- Writes:
  - On a rising edge with reset low, each enabled port writes its data to its address.
  - Writes to address 0 are discarded.
- Write conflict: when several enabled ports hit the same address, the highest-index port wins. wr_conflict is 1 in the following cycle if that address is nonzero.
- Reads:
  - rd_data[j] = 0 if rd_addr[j] == 0.
  - Otherwise, if any enabled write port targets rd_addr[j] this cycle, rd_data[j] is that port's wr_data (highest index wins). This is the write-first bypass.
  - Otherwise, rd_data[j] is the array contents.
- Scoreboard (when compiled in):
  - sb_set_en sets busy[sb_set_addr] at the edge.
  - Any enabled write clears busy[wr_addr] at the edge.
  - Set and clear of the same address in the same cycle: set wins, so the entry stays busy (a new producer is issued behind a retiring one).
  - Address 0 is never busy.
  - rd_busy[j] = busy[rd_addr[j]], masked to 0 when a write to rd_addr[j] is enabled this cycle. This masking is the bypass-consistent view.

## Timing
- Read latency: 0 cycles, combinational from rd_addr, wr_en, wr_addr and wr_data.
- Write latency: 1 cycle into the array; same-cycle visibility through the bypass.
- Scoreboard update: 1 cycle. rd_busy reflects a sb_set_en on the following cycle.
- wr_conflict: asserted exactly 1 cycle after the conflicting write. It deasserts the next cycle unless the conflict repeats.
- Reset (synchronous, active-high): at the first rising edge with reset high:
  - all entries clear to 0, all busy bits clear, wr_conflict clears to 0;
  - writes and sb_set_en in that cycle are ignored.
- Reset mid-operation: reset dominates every other input in the same cycle.
- Output values after reset:
  - rd_data = 0 for every address, except addresses being bypassed by an enabled write on the current cycle;
  - rd_busy = 0;
  - wr_conflict = 0.
- No handshake: all requests are accepted every cycle; there is no backpressure.

## Configuration
- REGFILE_MP_SCOREBOARD_EN defined:
  - busy vector and set/clear logic are present, as in Operation.
- Not defined:
  - busy vector removed; rd_busy tied to 0;
  - sb_set_en and sb_set_addr ignored;
  - all other behaviour is identical.

## Structure
- Package regfile_mp_pkg holds:
  - default DATA_W, ADDR_W, NUM_RD and NUM_WR constants;
  - a function returning the highest-index matching write port (shared by write resolution and bypass);
  - the register-0 address constant.
- Sub-module regfile_mp_scoreboard holds:
  - the DEPTH-bit busy vector with set/clear priority;
  - the per-read-port rd_busy masking.
- It is instantiated only under REGFILE_MP_SCOREBOARD_EN.

## Test plan
- Reset then sweep reads: all 32 addresses read 0, rd_busy = 0, wr_conflict = 0.
- Write 0xDEADBEEF to r5 via port 0 while reading r5 in the same cycle: rd_data = 0xDEADBEEF (bypass). Next cycle, with no write, r5 still reads 0xDEADBEEF.
- Port 0 writes 0x11 and port 1 writes 0x22, both to r7: r7 reads 0x22 afterwards; wr_conflict = 1 for exactly one cycle.
- Write 0x55 to r0: r0 reads 0 in the same cycle and afterwards; wr_conflict stays 0 even if both ports target r0.
- Scoreboard:
  - sb_set_en for r3 gives rd_busy = 1 next cycle;
  - a write to r3 gives rd_busy = 0 in the same cycle and afterwards;
  - set and write to r3 together leave rd_busy = 1 next cycle.
- Reset mid-operation: write 0xAA to r9 and set r9 busy, then assert reset together with a write of 0xBB to r9. Next cycle r9 reads 0 and rd_busy = 0.
